// File: rtl/pong_pkg.sv
// Shared screen geometry and sensor range constants for the pong datapath.
// Pure constants and types; no logic, no latency.
// No flow control; consumers share these values so they agree on ranges.
package pong_pkg;

    // Screen geometry: the paddle top may not go below VER_PIXELS - PADDLE_H.
    localparam int VER_PIXELS = 600;
    localparam int PADDLE_H   = 120;
    localparam int Y_MAX      = VER_PIXELS - PADDLE_H;

    // Accepted ultrasonic range in cm; MIN_CM maps to the top of the screen.
    localparam int MIN_CM     = 5;
    localparam int MAX_CM     = 40;

    // Datapath widths.
    localparam int DIST_W     = 9;   // raw distance in cm
    localparam int SUM_W      = 11;  // 4 * 511 = 2044 fits
    localparam int POS_W      = 11;  // paddle y coordinate
    localparam int CALC_W     = 12;  // scaling and signed slew arithmetic

    typedef logic [DIST_W-1:0] dist_t;
    typedef logic [SUM_W-1:0]  sum_t;
    typedef logic [POS_W-1:0]  ypos_t;

endpackage

// File: rtl/moving_avg4.sv
// 4-sample moving average with running sum and refill on first/recovered sample.
// Latency: window, sum and avg_valid all register one cycle after sample_vld.
// No backpressure: every sample_vld strobe is consumed in its cycle.
module moving_avg4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] sample,
    input  logic       sample_vld,
    input  logic       force_preload,
    output logic [8:0] avg,
    output logic       avg_valid
);
    import pong_pkg::*;

    // win[0] is the newest entry, win[3] the oldest.
    logic [3:0][DIST_W-1:0] win;
    sum_t                   sum;
    logic                   full;

    // Fill the whole window on the first sample (or after a lost sensor) so
    // the average jumps straight to the new reading; otherwise slide it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win       <= '0;
            sum       <= '0;
            full      <= 1'b0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= sample_vld;
            if (sample_vld) begin
                if (!full || force_preload) begin
                    win  <= {4{sample}};
                    sum  <= {sample, 2'b00};
                    full <= 1'b1;
                end else begin
                    win <= {win[2:0], sample};
                    sum <= sum + SUM_W'(sample) - SUM_W'(win[3]);
                end
            end
        end
    end

    // Floor of sum / 4.
    assign avg = sum[SUM_W-1:2];

endmodule

// File: rtl/paddle_pos_filter.sv
// Turns raw ultrasonic distance into a range-gated, averaged, slew-limited paddle Y.
// Latency: target 2 cycles after an accepted strobe; y_position moves only on frame_tick.
// No backpressure: samples and frame ticks are single-cycle strobes, never stalled.
module paddle_pos_filter #(
    parameter int MIN_CM         = pong_pkg::MIN_CM,
    parameter int MAX_CM         = pong_pkg::MAX_CM,
    parameter int SCALE_SHIFT    = 4,
    parameter int Y_MAX          = pong_pkg::Y_MAX,
    parameter int Y_RESET        = 240,
    parameter int MAX_STEP       = 8,
    parameter int TIMEOUT_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  distance,
    input  logic        distance_valid,
    input  logic        frame_tick,
    output logic [10:0] y_position,
    output logic        y_update,
    output logic        sensor_lost
);
    import pong_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_FRAMES + 1);

    logic                     accept;
    dist_t                    avg;
    logic                     avg_valid;
    logic [CALC_W-1:0]        t_scaled;
    ypos_t                    t_clamped;
    ypos_t                    target;
    logic signed [CALC_W-1:0] diff;
    ypos_t                    y_next;
    logic [CNT_W-1:0]         frame_cnt;

    // Out-of-range or unstrobed samples are dropped here and touch nothing downstream.
    assign accept = distance_valid
                  && (distance >= DIST_W'(MIN_CM))
                  && (distance <= DIST_W'(MAX_CM));

    moving_avg4 u_avg (
        .clk           (clk),
        .rst           (rst),
        .sample        (distance),
        .sample_vld    (accept),
        .force_preload (sensor_lost),
        .avg           (avg),
        .avg_valid     (avg_valid)
    );

    // Map cm to pixels; the average is never below MIN_CM because every
    // sample in the window passed the gate.
    always_comb begin
        t_scaled  = (CALC_W'(avg) - CALC_W'(MIN_CM)) << SCALE_SHIFT;
        t_clamped = (t_scaled > CALC_W'(Y_MAX)) ? POS_W'(Y_MAX) : t_scaled[POS_W-1:0];
    end

    // Register the clamped target whenever the averager produces a new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target <= POS_W'(Y_RESET);
        end else if (avg_valid) begin
            target <= t_clamped;
        end
    end

    // Step toward the target by at most MAX_STEP; snap when within reach.
    always_comb begin
        diff = $signed({1'b0, target}) - $signed({1'b0, y_position});
        if (diff > $signed(CALC_W'(MAX_STEP))) begin
            y_next = y_position + POS_W'(MAX_STEP);
        end else if (diff < -$signed(CALC_W'(MAX_STEP))) begin
            y_next = y_position - POS_W'(MAX_STEP);
        end else begin
            y_next = target;
        end
    end

    // Output only moves once per frame, so the paddle cannot tear mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_position <= POS_W'(Y_RESET);
            y_update   <= 1'b0;
        end else begin
            y_update <= frame_tick;
            if (frame_tick) begin
                y_position <= y_next;
            end
        end
    end

    // Frame-based watchdog; a good sample always wins over a same-cycle tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt   <= '0;
            sensor_lost <= 1'b1;
        end else if (accept) begin
            frame_cnt   <= '0;
            sensor_lost <= 1'b0;
        end else if (frame_tick && (frame_cnt != CNT_W'(TIMEOUT_FRAMES))) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (frame_cnt == CNT_W'(TIMEOUT_FRAMES - 1)) begin
                sensor_lost <= 1'b1;
            end
        end
    end

endmodule
